// File: rtl/led_pkg.sv
// led_pkg: shared constants for the LED breathing block.
// Holds the phase encodings reported on led_breathe.phase, the board clock
// frequency, and a counter-width helper.
package led_pkg;

  // Default board clock frequency.
  localparam int unsigned CLK_HZ = 25_000_000;

  // Breathing FSM phase encodings. These values appear directly on the phase port.
  localparam logic [1:0] UP      = 2'd0;
  localparam logic [1:0] HOLD_HI = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] HOLD_LO = 2'd3;

  // Bits needed to count 0..n-1. Always returns at least 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_breathe_pwm_gen.sv
// pwm_gen: free-running PWM counter plus the registered LED compare.
// The counter runs on every clock, whether or not en is set. en only gates
// the registered LED drive.
module pwm_gen
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty_eff,
  output logic                led
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Free-running PWM period counter that wraps at 2^PWM_BITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Registered compare. led is high for duty_eff counts of every period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= 1'b0;
    else     led <= en & (pwm_cnt < duty_eff);
  end

endmodule

// File: rtl/led_breathe.sv
// led_breathe: LED breathing controller.
// Ramps duty up, holds it at the top, ramps it down, holds it at the bottom,
// and repeats. One duty step happens per prescaler tick.
// Build option: define LED_BREATHE_GAMMA_EN to drive the PWM with
// (duty*duty)>>PWM_BITS instead of the linear duty. The duty output stays linear.
module led_breathe
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 97_656,
  parameter int unsigned HOLD_STEPS  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase
);

  localparam int unsigned PS_W = cnt_width(STEP_CYCLES);
  localparam int unsigned HC_W = cnt_width(HOLD_STEPS);

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_CYCLES - 1);
  localparam logic [HC_W-1:0]     HC_LAST  = HC_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [PS_W-1:0]     ps;
  logic                tick;
  logic [1:0]          state;
  logic [HC_W-1:0]     hold_cnt;
  logic [PWM_BITS-1:0] duty_eff;

  // Terminal-count tick. It only fires while enabled, so a gated block stays frozen.
  always_comb begin
    tick = en & (ps == PS_LAST);
  end

  // Step prescaler. It counts only while enabled and wraps after the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps <= '0;
    else if (en) begin
      if (tick)    ps <= '0;
      else         ps <= ps + 1'b1;
    end
  end

  // Breathing FSM. On each tick it steps duty or the hold counter, and it saturates at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UP;
      duty     <= '0;
      hold_cnt <= '0;
    end else if (tick) begin
      case (state)
        UP: begin
          if (duty == DUTY_MAX) begin
            state    <= HOLD_HI;
            hold_cnt <= '0;
          end else begin
            duty <= duty + 1'b1;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HC_LAST) state    <= DOWN;
          else                     hold_cnt <= hold_cnt + 1'b1;
        end
        DOWN: begin
          if (duty == '0) begin
            state    <= HOLD_LO;
            hold_cnt <= '0;
          end else begin
            duty <= duty - 1'b1;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HC_LAST) state    <= UP;
          else                     hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= UP;
      endcase
    end
  end

  // Phase reports the state register directly.
  always_comb begin
    phase = state;
  end

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;

  // Gamma stage. The square is formed at full double width, and its upper half becomes the PWM duty.
  always_comb begin
    duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  // Linear stage. The PWM duty is the ramp value itself.
  always_comb begin
    duty_eff = duty;
  end
`endif

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty_eff (duty_eff),
    .led      (led)
  );

endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: self-checking bench for led_breathe.
// Three instances run side by side:
//   a: PWM_BITS=8, STEP_CYCLES=1,  HOLD_STEPS=64 (reset in mid-ramp)
//   b: PWM_BITS=4, STEP_CYCLES=2,  HOLD_STEPS=2  (full cycle, gating, random en)
//   c: PWM_BITS=4, STEP_CYCLES=64, HOLD_STEPS=2  (long steps for extreme and gamma duty)
// The reference model derives the expected duty and phase from the number of
// elapsed ticks. The breathing trajectory is a fixed periodic sequence.
module tb_led_breathe;

`ifdef LED_BREATHE_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic led_a, led_b, led_c;
  logic [7:0] duty_a;
  logic [3:0] duty_b, duty_c;
  logic [1:0] phase_a, phase_b, phase_c;

  int checks = 0;
  int errors = 0;

  led_breathe #(.PWM_BITS(8), .STEP_CYCLES(1), .HOLD_STEPS(64)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .led(led_a), .duty(duty_a), .phase(phase_a));
  led_breathe #(.PWM_BITS(4), .STEP_CYCLES(2), .HOLD_STEPS(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .led(led_b), .duty(duty_b), .phase(phase_b));
  led_breathe #(.PWM_BITS(4), .STEP_CYCLES(64), .HOLD_STEPS(2)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .led(led_c), .duty(duty_c), .phase(phase_c));

  // ---------------- reference model ----------------
  // After k ticks, the trajectory is: UP for mx+1 ticks (duty 0..mx), HOLD_HI for h,
  // DOWN for mx+1 (duty mx..0), HOLD_LO for h. Then it repeats.
  function automatic int exp_duty(input longint k, input int b, input int h);
    int mx = (1 << b) - 1;
    longint p = longint'(2 * (mx + 1) + 2 * h);
    int m = int'(k % p);
    if (m <= mx)              return m;
    if (m <= mx + h)          return mx;
    if (m <= 2 * mx + h + 1)  return mx - (m - (mx + h + 1));
    return 0;
  endfunction

  function automatic int exp_phase(input longint k, input int b, input int h);
    int mx = (1 << b) - 1;
    longint p = longint'(2 * (mx + 1) + 2 * h);
    int m = int'(k % p);
    if (m <= mx)              return 0;
    if (m <= mx + h)          return 1;
    if (m <= 2 * mx + h + 1)  return 2;
    return 3;
  endfunction

  function automatic int eff(input int d, input int b);
    return GAMMA ? ((d * d) >> b) : d;
  endfunction

  // Per-instance counters: clocks since reset, and enabled clocks since reset.
  // Expected led comes from the pre-edge values.
  longint cyc_a, ecnt_a, cyc_b, ecnt_b, cyc_c, ecnt_c;
  logic   mled_a, mled_b, mled_c;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin cyc_a <= 0; ecnt_a <= 0; mled_a <= 1'b0; end
    else begin
      mled_a <= en_a && ((cyc_a % 256) < eff(exp_duty(ecnt_a, 8, 64), 8));
      cyc_a  <= cyc_a + 1;
      if (en_a) ecnt_a <= ecnt_a + 1;
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin cyc_b <= 0; ecnt_b <= 0; mled_b <= 1'b0; end
    else begin
      mled_b <= en_b && ((cyc_b % 16) < eff(exp_duty(ecnt_b / 2, 4, 2), 4));
      cyc_b  <= cyc_b + 1;
      if (en_b) ecnt_b <= ecnt_b + 1;
    end
  end

  always @(posedge clk or posedge rst_c) begin
    if (rst_c) begin cyc_c <= 0; ecnt_c <= 0; mled_c <= 1'b0; end
    else begin
      mled_c <= en_c && ((cyc_c % 16) < eff(exp_duty(ecnt_c / 64, 4, 2), 4));
      cyc_c  <= cyc_c + 1;
      if (en_c) ecnt_c <= ecnt_c + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({led_a, duty_a, phase_a} !== 11'd0) begin
      errors++; $display("FAIL reset_a: led=%b duty=%0d phase=%0d, required all 0", led_a, duty_a, phase_a);
    end
    checks++;
    if ({led_b, duty_b, phase_b} !== 7'd0) begin
      errors++; $display("FAIL reset_b: led=%b duty=%0d phase=%0d, required all 0", led_b, duty_b, phase_b);
    end
    checks++;
    if ({led_c, duty_c, phase_c} !== 7'd0) begin
      errors++; $display("FAIL reset_c: led=%b duty=%0d phase=%0d, required all 0", led_c, duty_c, phase_c);
    end
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  task automatic test_midramp_reset;
    int n = 0;
    while (exp_duty(ecnt_a, 8, 64) != 100 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL midramp_wait: model duty never reached 100 within 400 clk"); end
    checks++;
    if (duty_a !== 8'd100) begin errors++; $display("FAIL midramp_duty: duty=%0d, required 100", duty_a); end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({led_a, duty_a, phase_a} !== 11'd0) begin
      errors++; $display("FAIL async_reset: led=%b duty=%0d phase=%0d, required all 0", led_a, duty_a, phase_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({led_a, duty_a, phase_a} !== 11'd0) begin
      errors++; $display("FAIL reset_hold: led=%b duty=%0d phase=%0d, required all 0", led_a, duty_a, phase_a);
    end
    rst_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (led_a !== mled_a || duty_a !== 8'(exp_duty(ecnt_a, 8, 64)) || phase_a !== 2'(exp_phase(ecnt_a, 8, 64))) begin
        errors++;
        $display("FAIL restart_a[%0d]: led=%b duty=%0d phase=%0d, required led=%b duty=%0d phase=%0d",
                 i, led_a, duty_a, phase_a, mled_a, exp_duty(ecnt_a, 8, 64), exp_phase(ecnt_a, 8, 64));
      end
    end
  endtask

  task automatic test_full_cycle;
    int peak = 0, low = 15, t0 = -1, period = -1;
    logic [1:0] prev = phase_b;
    for (int i = 0; i < 400 && period < 0; i++) begin
      @(negedge clk);
      checks++;
      if (led_b !== mled_b || duty_b !== 4'(exp_duty(ecnt_b / 2, 4, 2)) || phase_b !== 2'(exp_phase(ecnt_b / 2, 4, 2))) begin
        errors++;
        $display("FAIL cycle_b[%0d]: led=%b duty=%0d phase=%0d, required led=%b duty=%0d phase=%0d",
                 i, led_b, duty_b, phase_b, mled_b, exp_duty(ecnt_b / 2, 4, 2), exp_phase(ecnt_b / 2, 4, 2));
      end
      if (int'(duty_b) > peak) peak = int'(duty_b);
      if (int'(duty_b) < low)  low  = int'(duty_b);
      if (prev == 2'd3 && phase_b == 2'd0) begin
        if (t0 < 0) t0 = i;
        else        period = i - t0;
      end
      prev = phase_b;
    end
    checks++;
    if (period != 72) begin errors++; $display("FAIL cycle_period: measured %0d clk, required 72", period); end
    checks++;
    if (peak != 15) begin errors++; $display("FAIL cycle_peak: peak duty %0d, required 15", peak); end
    checks++;
    if (low != 0) begin errors++; $display("FAIL cycle_floor: min duty %0d, required 0", low); end
  endtask

  task automatic test_extremes;
    int highs;
    int n;
    int lvls [3] = '{0, 8, 15};
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    foreach (lvls[j]) begin
      n = 0;
      while (!(ecnt_c == longint'(lvls[j] * 64 + 2)) && n < 1200) begin @(negedge clk); n++; end
      checks++;
      if (n >= 1200) begin errors++; $display("FAIL extreme_wait: duty %0d not reached within 1200 clk", lvls[j]); end
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (led_c === 1'b1) highs++;
        checks++;
        if (led_c !== mled_c || duty_c !== 4'(lvls[j])) begin
          errors++;
          $display("FAIL extreme_cycle d=%0d [%0d]: led=%b duty=%0d, required led=%b duty=%0d",
                   lvls[j], i, led_c, duty_c, mled_c, lvls[j]);
        end
      end
      checks++;
      if (highs != eff(lvls[j], 4)) begin
        errors++; $display("FAIL extreme_count d=%0d: led high %0d of 16, required %0d", lvls[j], highs, eff(lvls[j], 4));
      end
    end
  endtask

  task automatic test_gate;
    int n = 0;
    while (!(exp_duty(ecnt_b / 2, 4, 2) == 7 && exp_phase(ecnt_b / 2, 4, 2) == 0) && n < 200) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL gate_wait: duty 7 in UP not reached within 200 clk"); end
    en_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (led_b !== 1'b0 || duty_b !== 4'd7 || phase_b !== 2'd0) begin
        errors++; $display("FAIL gate_frozen[%0d]: led=%b duty=%0d phase=%0d, required led=0 duty=7 phase=0",
                           i, led_b, duty_b, phase_b);
      end
    end
    en_b = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (duty_b === 4'd7 && n < 6);
    checks++;
    if (duty_b !== 4'd8) begin errors++; $display("FAIL gate_resume: duty=%0d after %0d clk, required 8", duty_b, n); end
  endtask

  task automatic test_random_gate;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (led_b !== mled_b || duty_b !== 4'(exp_duty(ecnt_b / 2, 4, 2)) || phase_b !== 2'(exp_phase(ecnt_b / 2, 4, 2))) begin
        errors++;
        $display("FAIL random_b[%0d]: led=%b duty=%0d phase=%0d, required led=%b duty=%0d phase=%0d",
                 i, led_b, duty_b, phase_b, mled_b, exp_duty(ecnt_b / 2, 4, 2), exp_phase(ecnt_b / 2, 4, 2));
      end
      en_b = ($urandom_range(0, 3) != 0);
    end
    en_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_midramp_reset();
    test_full_cycle();
    test_extremes();
    test_gate();
    test_random_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
